// File: rtl/regdst_hazard_ctrl_if.sv
// Register-destination / hazard control bundle between the ID-stage decode
// and the hazard controller. Optional stats counters need HAZARD_STALL_STATS_EN.
interface regdst_hazard_ctrl_if;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic [4:0] id_rd;
    logic       id_reg_dst;
    logic       id_reg_write;
    logic       id_mem_read;
    logic       id_uses_rt;
    logic       flush;
    logic       dst_sel;
    logic       stall;
    logic [4:0] ex_dst;
    logic [4:0] mem_dst;
    logic [4:0] wb_dst;
    logic       wb_we;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
`ifdef HAZARD_STALL_STATS_EN
    logic [15:0] stall_count;
    logic [15:0] flush_count;
`endif

    modport master (
        output id_valid, id_rs, id_rt, id_rd,
        output id_reg_dst, id_reg_write,
        output id_mem_read, id_uses_rt, flush,
        input  dst_sel, stall,
        input  ex_dst, mem_dst, wb_dst,
        input  wb_we, fwd_a, fwd_b
`ifdef HAZARD_STALL_STATS_EN
        , input stall_count, flush_count
`endif
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rd,
        input  id_reg_dst, id_reg_write,
        input  id_mem_read, id_uses_rt, flush,
        output dst_sel, stall,
        output ex_dst, mem_dst, wb_dst,
        output wb_we, fwd_a, fwd_b
`ifdef HAZARD_STALL_STATS_EN
        , output stall_count, flush_count
`endif
    );
endinterface

// File: rtl/regdst_hazard_ctrl.sv
// Destination tracking, load-use stall FSM and EX forwarding selects.
// Ports: clk, reset_n (sync, active-low), bus (regdst_hazard_ctrl_if.slave).
// HAZARD_STALL_STATS_EN adds stall_count/flush_count on the bus.
module regdst_hazard_ctrl #(
    parameter int unsigned LOAD_STALL_CYCLES = 1,
    parameter logic [4:0]  ZERO_REG          = 5'd0
) (
    input  logic clk,
    input  logic reset_n,
    regdst_hazard_ctrl_if.slave bus
);
    typedef enum logic {IDLE, STALL} state_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] dst;
        logic       we;
        logic       load;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
    } ex_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] dst;
        logic       we;
        logic       load;
    } mem_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] dst;
        logic       we;
    } wb_t;

    // The hazard cycle itself is the first bubble; the counter covers the rest.
    localparam logic [1:0] STALL_INIT = 2'(LOAD_STALL_CYCLES - 1);

    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    ex_t        ex_q, ex_d;
    mem_t       mem_q, mem_d;
    wb_t        wb_q, wb_d;
    logic       hazard;
    logic       stall;
    logic       wb_we;
    logic       mem_fwd_ok;

    assign hazard = ex_q.valid && ex_q.load && ex_q.we &&
                    (ex_q.dst != ZERO_REG) && bus.id_valid &&
                    ((ex_q.dst == bus.id_rs) ||
                     (bus.id_uses_rt && (ex_q.dst == bus.id_rt)));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        unique case (state_q)
            IDLE: begin
                // A flushed consumer is dead, so it needs no bubble.
                if (hazard && !bus.flush) begin
                    stall = 1'b1;
                    if (STALL_INIT != 2'd0) begin
                        cnt_d   = STALL_INIT;
                        state_d = STALL;
                    end
                end
            end
            STALL: begin
                stall = 1'b1;
                cnt_d = cnt_q - 2'd1;
                if (cnt_q == 2'd1) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ex_d = '0;
        if (bus.id_valid && !stall && !bus.flush) begin
            ex_d.valid   = 1'b1;
            ex_d.dst     = bus.id_reg_dst ? bus.id_rd : bus.id_rt;
            ex_d.we      = bus.id_reg_write;
            ex_d.load    = bus.id_mem_read;
            ex_d.rs      = bus.id_rs;
            ex_d.rt      = bus.id_rt;
            ex_d.uses_rt = bus.id_uses_rt;
        end
        mem_d = '{valid: ex_q.valid, dst: ex_q.dst,
                  we: ex_q.we, load: ex_q.load};
        wb_d  = '{valid: mem_q.valid, dst: mem_q.dst,
                  we: mem_q.we};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            wb_q    <= wb_d;
        end
    end

    assign wb_we = wb_q.valid && wb_q.we && (wb_q.dst != ZERO_REG);

    // Loads in MEM have no data yet; the stall moves them to WB first.
    assign mem_fwd_ok = mem_q.valid && mem_q.we && !mem_q.load &&
                        (mem_q.dst != ZERO_REG);

    always_comb begin
        bus.fwd_a = 2'b00;
        if (mem_fwd_ok && (mem_q.dst == ex_q.rs))
            bus.fwd_a = 2'b10;
        else if (wb_we && (wb_q.dst == ex_q.rs))
            bus.fwd_a = 2'b01;
    end

    always_comb begin
        bus.fwd_b = 2'b00;
        if (ex_q.uses_rt) begin
            if (mem_fwd_ok && (mem_q.dst == ex_q.rt))
                bus.fwd_b = 2'b10;
            else if (wb_we && (wb_q.dst == ex_q.rt))
                bus.fwd_b = 2'b01;
        end
    end

    assign bus.dst_sel = bus.id_reg_dst;
    assign bus.stall   = stall;
    assign bus.ex_dst  = ex_q.dst;
    assign bus.mem_dst = mem_q.dst;
    assign bus.wb_dst  = wb_q.dst;
    assign bus.wb_we   = wb_we;

`ifdef HAZARD_STALL_STATS_EN
    logic [15:0] stall_count_q, stall_count_d;
    logic [15:0] flush_count_q, flush_count_d;

    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (stall && (stall_count_q != 16'hFFFF))
            stall_count_d = stall_count_q + 16'd1;
        if (bus.flush && (flush_count_q != 16'hFFFF))
            flush_count_d = flush_count_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign bus.stall_count = stall_count_q;
    assign bus.flush_count = flush_count_q;
`endif
endmodule

// File: tb/tb_regdst_hazard_ctrl.sv
// Directed bench for regdst_hazard_ctrl: reset, forwarding, load-use,
// flush and zero-register cases; stats run on a second instance.
module tb_regdst_hazard_ctrl;
    logic clk;
    logic reset_n;
    int   nchk;
    int   nfail;

    regdst_hazard_ctrl_if hif();

    regdst_hazard_ctrl #(.LOAD_STALL_CYCLES(1)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (hif.slave)
    );

`ifdef HAZARD_STALL_STATS_EN
    regdst_hazard_ctrl_if hif2();

    regdst_hazard_ctrl #(.LOAD_STALL_CYCLES(2)) dut2 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (hif2.slave)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic v, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd,
                       input logic rdst, input logic wr, input logic mr,
                       input logic urt, input logic fl);
        hif.id_valid     = v;
        hif.id_rs        = rs;
        hif.id_rt        = rt;
        hif.id_rd        = rd;
        hif.id_reg_dst   = rdst;
        hif.id_reg_write = wr;
        hif.id_mem_read  = mr;
        hif.id_uses_rt   = urt;
        hif.flush        = fl;
`ifdef HAZARD_STALL_STATS_EN
        hif2.id_valid     = v;
        hif2.id_rs        = rs;
        hif2.id_rt        = rt;
        hif2.id_rd        = rd;
        hif2.id_reg_dst   = rdst;
        hif2.id_reg_write = wr;
        hif2.id_mem_read  = mr;
        hif2.id_uses_rt   = urt;
        hif2.flush        = fl;
`endif
        #1;
    endtask

    task automatic bubble();
        put(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        nchk    = 0;
        nfail   = 0;
        reset_n = 1'b0;

        // reset held three cycles with a valid add r3 in ID
        put(1, 1, 2, 3, 1, 1, 0, 1, 0);
        repeat (3) cyc();
        chk("rst_stall", hif.stall, 0);
        chk("rst_wb_we", hif.wb_we, 0);
        chk("rst_fwd_a", hif.fwd_a, 0);
        chk("rst_fwd_b", hif.fwd_b, 0);
        chk("rst_ex_dst", hif.ex_dst, 0);
        chk("rst_mem_dst", hif.mem_dst, 0);
        chk("rst_wb_dst", hif.wb_dst, 0);
        chk("rst_dst_sel", hif.dst_sel, 1);
        reset_n = 1'b1;
        cyc();
        chk("rel1_wb_we", hif.wb_we, 0);
        chk("rel1_ex_dst", hif.ex_dst, 3);
        cyc();
        chk("rel2_wb_we", hif.wb_we, 0);
        cyc();
        chk("rel3_wb_we", hif.wb_we, 1);
        chk("rel3_wb_dst", hif.wb_dst, 3);
        bubble();
        repeat (3) cyc();
        chk("drain_wb_we", hif.wb_we, 0);

        // add r5 ; sub rs=r5 ; or rs=r5 rt=r6
        put(1, 1, 2, 5, 1, 1, 0, 1, 0);
        chk("add_dst_sel", hif.dst_sel, 1);
        cyc();
        chk("add_ex_dst", hif.ex_dst, 5);
        put(1, 5, 2, 6, 1, 1, 0, 1, 0);
        chk("sub_no_stall", hif.stall, 0);
        cyc();
        chk("sub_fwd_a", hif.fwd_a, 2'b10);
        chk("sub_fwd_b", hif.fwd_b, 2'b00);
        put(1, 5, 6, 7, 1, 1, 0, 1, 0);
        cyc();
        chk("or_fwd_a", hif.fwd_a, 2'b01);
        chk("or_fwd_b", hif.fwd_b, 2'b10);
        chk("or_wb_we", hif.wb_we, 1);
        chk("or_wb_dst", hif.wb_dst, 5);

        // two writers of r9: newest (MEM) wins; rt unused gives 00
        put(1, 1, 2, 9, 1, 1, 0, 1, 0);
        cyc();
        put(1, 3, 4, 9, 1, 1, 0, 1, 0);
        cyc();
        put(1, 9, 9, 13, 1, 1, 0, 0, 0);
        cyc();
        chk("prio_fwd_a", hif.fwd_a, 2'b10);
        chk("norrt_fwd_b", hif.fwd_b, 2'b00);
        bubble();
        repeat (3) cyc();

        // lw r8 ; add rs=r8 -> one bubble then WB forward
        put(1, 1, 8, 0, 0, 1, 1, 0, 0);
        chk("lw_dst_sel", hif.dst_sel, 0);
        cyc();
        chk("lw_ex_dst", hif.ex_dst, 8);
        put(1, 8, 3, 10, 1, 1, 0, 1, 0);
        chk("lu_stall", hif.stall, 1);
        cyc();
        chk("lu_stall_end", hif.stall, 0);
        chk("lu_mem_dst", hif.mem_dst, 8);
        chk("lu_bub_fwd_a", hif.fwd_a, 2'b00);
        cyc();
        chk("lu_fwd_a", hif.fwd_a, 2'b01);
        chk("lu_ex_dst", hif.ex_dst, 10);
        chk("lu_wb_we", hif.wb_we, 1);
        bubble();
        repeat (3) cyc();

        // load-use through rt only when rt is a source
        put(1, 1, 14, 0, 0, 1, 1, 0, 0);
        cyc();
        put(1, 2, 14, 15, 1, 1, 0, 1, 0);
        chk("rt_stall", hif.stall, 1);
        put(1, 2, 14, 15, 1, 1, 0, 0, 0);
        chk("rt_unused_stall", hif.stall, 0);
        bubble();
        repeat (3) cyc();

        // lw r8 ; consumer killed by flush on the hazard cycle
        put(1, 1, 8, 0, 0, 1, 1, 0, 0);
        cyc();
        put(1, 8, 3, 11, 1, 1, 0, 1, 1);
        chk("fl_stall", hif.stall, 0);
        cyc();
        bubble();
        chk("fl_fwd_a", hif.fwd_a, 2'b00);
        cyc();
        chk("fl_lw_wb_we", hif.wb_we, 1);
        chk("fl_lw_wb_dst", hif.wb_dst, 8);
        cyc();
        chk("fl_killed_wb_we", hif.wb_we, 0);

        // writes to r0 never forward or write back
        put(1, 1, 2, 0, 1, 1, 0, 1, 0);
        cyc();
        put(1, 0, 0, 12, 1, 1, 0, 1, 0);
        chk("z_stall", hif.stall, 0);
        cyc();
        chk("z_mem_fwd_a", hif.fwd_a, 2'b00);
        chk("z_mem_fwd_b", hif.fwd_b, 2'b00);
        cyc();
        chk("z_wb_fwd_a", hif.fwd_a, 2'b00);
        chk("z_wb_we", hif.wb_we, 0);
        put(1, 1, 0, 0, 0, 1, 1, 0, 0);
        cyc();
        put(1, 0, 0, 12, 1, 1, 0, 1, 0);
        chk("z_lw_stall", hif.stall, 0);
        bubble();
        repeat (3) cyc();

`ifdef HAZARD_STALL_STATS_EN
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        chk("st_rst_stall_cnt", hif2.stall_count, 0);
        chk("st_rst_flush_cnt", hif2.flush_count, 0);
        put(1, 1, 8, 0, 0, 1, 1, 0, 0);
        cyc();
        put(1, 8, 3, 10, 1, 1, 0, 1, 0);
        chk("st_p1_stall", hif2.stall, 1);
        cyc();
        chk("st_p1_stall2", hif2.stall, 1);
        cyc();
        chk("st_p1_stall_end", hif2.stall, 0);
        cyc();
        put(1, 1, 9, 0, 0, 1, 1, 0, 0);
        cyc();
        put(1, 9, 3, 10, 1, 1, 0, 1, 0);
        repeat (3) cyc();
        chk("st_stall_cnt4", hif2.stall_count, 4);
        put(0, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc();
        chk("st_flush_cnt1", hif2.flush_count, 1);
        put(1, 1, 10, 0, 0, 1, 1, 0, 0);
        cyc();
        put(1, 10, 3, 10, 1, 1, 0, 1, 0);
        cyc();
        chk("st_mid_stall", hif2.stall, 1);
        reset_n = 1'b0;
        cyc();
        chk("st_rst_stall", hif2.stall, 0);
        chk("st_rst_cnt", hif2.stall_count, 0);
        reset_n = 1'b1;
        bubble();
        cyc();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nchk, nfail);
        $finish;
    end
endmodule

// File: doc/regdst_hazard_ctrl.md
Name: regdst_hazard_ctrl

Overview:
Sequencing controller for the 5-bit register-destination path of the 5-stage pipeline.
- Drives the select of the ID-stage destination mux: rt when select=0, rd when select=1.
- Carries the selected destination address with write/load flags through the EX, MEM and WB stages.
- Detects load-use hazards, inserts bubbles and generates the EX-stage ALU operand forwarding selects.
- Sits beside the ID/EX, EX/MEM and MEM/WB pipeline registers. Consumes decoded control, produces stall and forward controls.

Parameters:
- LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..3).
- ZERO_REG, 0, register address that never creates a hazard or a forward.

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset_n  input  1  synchronous active-low reset.
- id_valid  input  1  ID stage holds a real instruction.
- id_rs  input  5  ID source address A.
- id_rt  input  5  ID source address B / I-type destination.
- id_rd  input  5  ID R-type destination.
- id_reg_dst  input  1  decoded destination choice (1=rd).
- id_reg_write  input  1  ID instruction writes the register file.
- id_mem_read  input  1  ID instruction is a load.
- id_uses_rt  input  1  ID instruction reads rt as a source.
- flush  input  1  branch/jump taken; kill the instruction entering EX.
- dst_sel  output  1  select to the destination mux.
- stall  output  1  hold PC and IF/ID; the instruction entering EX becomes a bubble.
- ex_dst / mem_dst / wb_dst  output  5 each  tracked destination per stage.
- wb_we  output  1  register-file write enable for the WB stage.
- fwd_a, fwd_b  output  2 each  EX operand select: 00=regfile, 10=EX/MEM, 01=MEM/WB.

Behaviour:
- dst_sel = id_reg_dst, combinational. Destination entering EX = id_reg_dst ? id_rd : id_rt.
- Per-stage state, all registered:
  - EX: valid, dst, we, load, rs, rt, uses_rt.
  - MEM: valid, dst, we, load.
  - WB: valid, dst, we.
- Reset (reset_n=0 at a clk edge):
  - All valids, we and load flags, dst fields and the stall counter clear to 0.
  - Outputs: stall=0, wb_we=0, fwd_a=fwd_b=00, all dst outputs=0.
  - Reset mid-stall abandons the stall immediately.
- Hazard condition, evaluated when idle: EX.valid && EX.load && EX.we && EX.dst!=ZERO_REG && id_valid, and either EX.dst==id_rs, or id_uses_rt && EX.dst==id_rt.
- FSM states:
  - IDLE: stall=0. On a hazard, load the counter with LOAD_STALL_CYCLES-1, go to STALL, and assert stall combinationally in the same cycle.
  - STALL: stall=1. Decrement the counter each cycle; return to IDLE when it reads 0 at a clk edge.
- Advance rules:
  - MEM->WB and EX->MEM advance every cycle, including during stall.
  - ID->EX loads a bubble (valid=0, we=0) when stall or flush is high; otherwise it loads the ID fields.
  - id_valid=0 loads a bubble.
- Simultaneous flush and hazard: flush wins. stall=0 and the FSM stays in IDLE, because the ID instruction is killed.
- wb_we = WB.valid && WB.we && WB.dst!=ZERO_REG.
- Forwarding, combinational from EX sources:
  - fwd_a=10 if MEM.valid && MEM.we && !MEM.load && MEM.dst!=ZERO_REG && MEM.dst==EX.rs.
  - Otherwise fwd_a=01 if wb_we && WB.dst==EX.rs.
  - Otherwise fwd_a=00.
  - MEM has priority over WB (newest value).
  - fwd_b uses the same rules with EX.rt, and is 00 when !EX.uses_rt.
  - A load in MEM never forwards; the stall guarantees the load has reached WB before its consumer is in EX.
- Writes to ZERO_REG are tracked but never hazard, never forward and never assert wb_we.

Optional Feature:
- HAZARD_STALL_STATS_EN.
- Defined:
  - Adds output stall_count[15:0]. It increments on every clk where stall=1, saturates at 16'hFFFF and resets to 0.
  - Adds output flush_count[15:0] with the same rules, counting flush cycles.
- Undefined: neither port exists and no counter logic is generated.

Test Plan:
- Reset held 3 cycles with id_valid=1 -> stall=0, wb_we=0, fwd_a=fwd_b=00, all dst=0. First write appears on wb_we exactly 3 cycles after release.
- R-type add rd=5 (reg_dst=1), then sub rs=5 -> dst_sel=1, ex_dst=5. The next cycle fwd_a=10. A third instruction reading r5 sees fwd_a=01.
- lw rt=8 (reg_dst=0, mem_read=1), then add rs=8 -> stall=1 for exactly LOAD_STALL_CYCLES (1) cycle and a bubble enters EX. The add then reaches EX with fwd_a=01.
- lw rt=8 followed by a consumer with flush=1 on the hazard cycle -> stall=0, EX valid=0, no forward generated.
- Instruction writing r0 followed by a reader of r0 -> no stall, fwd_a=00, wb_we=0.
- With HAZARD_STALL_STATS_EN and LOAD_STALL_CYCLES=2: two load-use pairs -> stall_count=4. reset_n=0 mid-stall -> stall drops the next cycle and stall_count=0.
